// File: rtl/img_window_ctrl.sv
// Image-window scheduler: turns raster counters into image-ROM reads and blanked RGB,
// and bounces the window across the active area once per frame with a pause at each edge.
module img_window_ctrl #(
   parameter int H_ACT_BEGIN    = 191,
   parameter int V_ACT_BEGIN    = 40,
   parameter int H_ACT          = 1920,
   parameter int V_ACT          = 1080,
   parameter int IMG_W          = 200,
   parameter int IMG_H          = 200,
   parameter int STEP           = 2,
   parameter int PAUSE_FRAMES   = 30,
   parameter int X_INIT         = 760,
   parameter int Y_INIT         = 440,
   parameter bit DIR_X_NEG_INIT = 1'b0,
   parameter bit DIR_Y_NEG_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] hcount,
   input  logic [12:0] vcount,
   input  logic        frame_tick,
   input  logic        move_en,
   output logic [15:0] rom_addr,
   input  logic [15:0] rom_dout,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic [10:0] pos_x,
   output logic [10:0] pos_y,
   output logic        at_edge
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} stateT;

   localparam int CNT_W = $clog2(PAUSE_FRAMES + 1);
   localparam logic signed [11:0] X_MAX_S = 12'(H_ACT - IMG_W);
   localparam logic signed [11:0] Y_MAX_S = 12'(V_ACT - IMG_H);

   stateT             r_state;
   logic [10:0]       r_posX;
   logic [10:0]       r_posY;
   logic              r_dirXNeg;
   logic              r_dirYNeg;
   logic [CNT_W-1:0]  r_cnt;
   logic [15:0]       r_romAddr;
   logic [15:0]       r_rowBase;
   logic              r_win1;
   logic              r_win2;
   logic [11:0]       r_rgb;

   stateT             w_nextState;
   logic [10:0]       w_nextPosX;
   logic [10:0]       w_nextPosY;
   logic              w_nextDirX;
   logic              w_nextDirY;
   logic [CNT_W-1:0]  w_nextCnt;

   logic [12:0]       w_winX0;
   logic [12:0]       w_winY0;
   logic [12:0]       w_col;
   logic              w_inWin;
   logic              w_firstLine;
   logic              w_lastCol;
   logic [15:0]       w_base;
   logic [15:0]       w_addr;
   logic              w_unused;

   logic signed [11:0] w_sumX;
   logic signed [11:0] w_sumY;
   logic              w_loX;
   logic              w_hiX;
   logic              w_loY;
   logic              w_hiY;
   logic [10:0]       w_clampX;
   logic [10:0]       w_clampY;

   // Window origin in raster coordinates; address is built incrementally, no multiplier.
   assign w_winX0     = 13'(H_ACT_BEGIN) + {2'b00, r_posX};
   assign w_winY0     = 13'(V_ACT_BEGIN) + {2'b00, r_posY};
   assign w_inWin     = (hcount >= w_winX0) && (hcount < w_winX0 + 13'(IMG_W)) &&
                        (vcount >= w_winY0) && (vcount < w_winY0 + 13'(IMG_H));
   assign w_col       = hcount - w_winX0;
   assign w_firstLine = (vcount == w_winY0);
   assign w_lastCol   = (w_col == 13'(IMG_W - 1));
   assign w_base      = w_firstLine ? 16'd0 : r_rowBase;
   assign w_addr      = w_base + 16'(w_col);
   assign w_unused    = ^{rom_dout[11], rom_dout[6:5], rom_dout[0]};

   // 3-clock path: addr/win1, ROM data/win2, registered RGB.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_romAddr <= '0;
         r_rowBase <= '0;
         r_win1    <= 1'b0;
         r_win2    <= 1'b0;
         r_rgb     <= '0;
      end else begin
         r_win1 <= w_inWin;
         r_win2 <= r_win1;
         r_rgb  <= r_win2 ? {rom_dout[15:12], rom_dout[10:7], rom_dout[4:1]} : 12'h000;
         if (w_inWin) begin
            r_romAddr <= w_addr;
            if (w_lastCol) begin
               r_rowBase <= w_base + 16'(IMG_W);
            end
         end
      end
   end

   // Signed 12-bit sums expose underflow below 0 before clamping.
   assign w_sumX   = r_dirXNeg ? ($signed({1'b0, r_posX}) - $signed(12'(STEP)))
                               : ($signed({1'b0, r_posX}) + $signed(12'(STEP)));
   assign w_sumY   = r_dirYNeg ? ($signed({1'b0, r_posY}) - $signed(12'(STEP)))
                               : ($signed({1'b0, r_posY}) + $signed(12'(STEP)));
   assign w_loX    = (w_sumX <= 12'sd0);
   assign w_hiX    = (w_sumX >= X_MAX_S);
   assign w_loY    = (w_sumY <= 12'sd0);
   assign w_hiY    = (w_sumY >= Y_MAX_S);
   assign w_clampX = w_loX ? 11'd0 : (w_hiX ? 11'(H_ACT - IMG_W) : w_sumX[10:0]);
   assign w_clampY = w_loY ? 11'd0 : (w_hiY ? 11'(V_ACT - IMG_H) : w_sumY[10:0]);

   always_comb begin
      w_nextState = r_state;
      w_nextPosX  = r_posX;
      w_nextPosY  = r_posY;
      w_nextDirX  = r_dirXNeg;
      w_nextDirY  = r_dirYNeg;
      w_nextCnt   = r_cnt;
      if (frame_tick) begin
         unique case (r_state)
            IDLE: begin
               if (move_en) begin
                  w_nextState = RUN;
               end
            end
            RUN: begin
               if (!move_en) begin
                  w_nextState = IDLE;
               end else begin
                  w_nextPosX = w_clampX;
                  w_nextPosY = w_clampY;
                  if (w_loX || w_hiX) begin
                     w_nextDirX = ~r_dirXNeg;
                  end
                  if (w_loY || w_hiY) begin
                     w_nextDirY = ~r_dirYNeg;
                  end
                  if (w_loX || w_hiX || w_loY || w_hiY) begin
                     w_nextState = PAUSE;
                     w_nextCnt   = CNT_W'(PAUSE_FRAMES - 1);
                  end
               end
            end
            PAUSE: begin
               if (r_cnt == '0) begin
                  w_nextState = move_en ? RUN : IDLE;
               end else begin
                  w_nextCnt = r_cnt - CNT_W'(1);
               end
            end
            default: w_nextState = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_posX    <= 11'(X_INIT);
         r_posY    <= 11'(Y_INIT);
         r_dirXNeg <= DIR_X_NEG_INIT;
         r_dirYNeg <= DIR_Y_NEG_INIT;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_nextState;
         r_posX    <= w_nextPosX;
         r_posY    <= w_nextPosY;
         r_dirXNeg <= w_nextDirX;
         r_dirYNeg <= w_nextDirY;
         r_cnt     <= w_nextCnt;
      end
   end

   assign rom_addr = r_romAddr;
   assign red      = r_rgb[11:8];
   assign green    = r_rgb[7:4];
   assign blue     = r_rgb[3:0];
   assign pos_x    = r_posX;
   assign pos_y    = r_posY;
   assign at_edge  = (r_state == PAUSE);

endmodule

// File: tb/tb_img_window_ctrl.sv
// Bench for img_window_ctrl: scoreboarded pixel path on the default instance, plus two
// extra instances started near the edges to exercise bounce and pause.
module tb_img_window_ctrl;

   localparam int H0 = 191;
   localparam int V0 = 40;
   localparam int IW = 200;
   localparam int IH = 200;

   typedef struct packed {
      logic [31:0] due;
      logic [15:0] val;
   } expT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [12:0] hcount;
   logic [12:0] vcount;
   logic        frameTick;
   logic        moveEn;
   logic        moveEnE;
   logic        moveEnC;

   logic [15:0] romAddr, romDout;
   logic [3:0]  red, green, blue;
   logic [10:0] posX, posY;
   logic        atEdge;

   logic [15:0] romAddrE, romAddrC;
   logic [3:0]  redE, greenE, blueE, redC, greenC, blueC;
   logic [10:0] posXE, posYE, posXC, posYC;
   logic        atEdgeE, atEdgeC;

   int  cycle = 0;
   int  vectorCount = 0;
   int  missCount = 0;
   int  mx;
   int  my;
   expT addrQ[$];
   expT rgbQ[$];

   img_window_ctrl dut (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .frame_tick(frameTick),
      .move_en(moveEn), .rom_addr(romAddr), .rom_dout(romDout), .red(red), .green(green),
      .blue(blue), .pos_x(posX), .pos_y(posY), .at_edge(atEdge)
   );

   img_window_ctrl #(.X_INIT(1718)) dutE (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .frame_tick(frameTick),
      .move_en(moveEnE), .rom_addr(romAddrE), .rom_dout(16'h0000), .red(redE), .green(greenE),
      .blue(blueE), .pos_x(posXE), .pos_y(posYE), .at_edge(atEdgeE)
   );

   img_window_ctrl #(.X_INIT(1), .Y_INIT(1), .DIR_X_NEG_INIT(1'b1), .DIR_Y_NEG_INIT(1'b1)) dutC (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .frame_tick(frameTick),
      .move_en(moveEnC), .rom_addr(romAddrC), .rom_dout(16'h0000), .red(redC), .green(greenC),
      .blue(blueC), .pos_x(posXC), .pos_y(posYC), .at_edge(atEdgeC)
   );

   function automatic logic [15:0] romData(input logic [15:0] a);
      return (a * 16'h9E37) ^ {a[7:0], a[15:8]} ^ 16'h5A5A;
   endfunction

   function automatic logic [11:0] rgbOf(input logic [15:0] d);
      return {d[15:12], d[10:7], d[4:1]};
   endfunction

   // One-cycle-latency ROM model and a free-running cycle index for the scoreboard.
   always @(posedge clk) begin
      romDout <= romData(romAddr);
      cycle   <= cycle + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Retire scoreboard entries whose due cycle has arrived.
   always @(negedge clk) begin
      while (addrQ.size() > 0 && addrQ[0].due == cycle) begin
         checkOutput("romAddr", 32'(romAddr), 32'(addrQ[0].val));
         addrQ.delete(0);
      end
      while (rgbQ.size() > 0 && rgbQ[0].due == cycle) begin
         checkOutput("rgb", 32'({red, green, blue}), 32'(rgbQ[0].val));
         rgbQ.delete(0);
      end
   end

   task automatic applyStimulus(input int h, input int v, input logic tick);
      expT e;
      int  col;
      int  row;
      logic [15:0] a;
      @(posedge clk);
      #1;
      hcount    = 13'(h);
      vcount    = 13'(v);
      frameTick = tick;
      col = h - (H0 + mx);
      row = v - (V0 + my);
      e.val = 16'h0000;
      if (col >= 0 && col < IW && row >= 0 && row < IH) begin
         a     = 16'(row * IW + col);
         e.due = 32'(cycle + 1);
         e.val = a;
         addrQ.push_back(e);
         e.val = {4'h0, rgbOf(romData(a))};
      end
      e.due = 32'(cycle + 3);
      rgbQ.push_back(e);
   endtask

   task automatic pulseFrame();
      applyStimulus(2199, 1124, 1'b1);
      applyStimulus(0, 0, 1'b0);
      @(negedge clk);
   endtask

   task automatic doReset(input int h, input int v);
      expT e;
      @(posedge clk);
      #1;
      rst       = 1'b1;
      hcount    = 13'(h);
      vcount    = 13'(v);
      frameTick = 1'b0;
      addrQ.delete();
      rgbQ.delete();
      e.due = 32'(cycle + 1);
      e.val = 16'h0000;
      addrQ.push_back(e);
      rgbQ.push_back(e);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      hcount = 13'd0;
      vcount = 13'd0;
   endtask

   task automatic scanWindow(input int lastLine);
      int x0;
      int y0;
      x0 = H0 + mx;
      y0 = V0 + my;
      applyStimulus(H0, V0, 1'b0);
      for (int v = y0 - 1; v <= lastLine; v++) begin
         applyStimulus(x0 - 1, v, 1'b0);
         applyStimulus(x0, v, 1'b0);
         applyStimulus(x0 + 1 + int'($urandom_range(IW - 3)), v, 1'b0);
         applyStimulus(x0 + IW - 1, v, 1'b0);
         applyStimulus(x0 + IW, v, 1'b0);
      end
   endtask

   task automatic checkPos(input string tag, input int ex, input int ey);
      checkOutput({tag, "_x"}, 32'(posX), 32'(ex));
      checkOutput({tag, "_y"}, 32'(posY), 32'(ey));
   endtask

   initial begin
      rst = 1'b1; hcount = '0; vcount = '0; frameTick = 1'b0;
      moveEn = 1'b0; moveEnE = 1'b0; moveEnC = 1'b0;
      mx = 760; my = 440;
      repeat (2) @(posedge clk);
      doReset(0, 0);
      @(negedge clk);
      checkPos("rstPos", 760, 440);
      checkOutput("rstEdge", 32'(atEdge), 0);
      checkOutput("rstPosXE", 32'(posXE), 1718);
      checkOutput("rstPosXC", 32'(posXC), 1);

      // Stationary window: full-frame address and blanking checks.
      pulseFrame();
      checkPos("idlePos", 760, 440);
      scanWindow(V0 + my + IH);

      // Motion, freeze and resume.
      moveEn = 1'b1;
      pulseFrame(); checkPos("runEnter", 760, 440);
      pulseFrame(); checkPos("run1", 762, 442);
      pulseFrame(); checkPos("run2", 764, 444);
      moveEn = 1'b0;
      pulseFrame(); checkPos("freeze1", 764, 444);
      pulseFrame(); checkPos("freeze2", 764, 444);
      moveEn = 1'b1;
      pulseFrame(); checkPos("resumeEnter", 764, 444);
      pulseFrame(); checkPos("resume1", 766, 446);
      moveEn = 1'b0;
      pulseFrame(); checkPos("stop", 766, 446);
      mx = 766; my = 446;

      // Reset in the middle of the window, then a full clean frame from INIT.
      scanWindow(499);
      doReset(H0 + mx + 10, 500);
      mx = 760; my = 440;
      @(negedge clk);
      checkPos("midRstPos", 760, 440);
      checkOutput("midRstEdge", 32'(atEdge), 0);
      scanWindow(V0 + my + IH);

      // Edge bounce on the right edge and in the top-left corner.
      moveEnE = 1'b1;
      moveEnC = 1'b1;
      pulseFrame();
      checkOutput("edgeEnterXE", 32'(posXE), 1718);
      checkOutput("edgeEnterXC", 32'(posXC), 1);
      pulseFrame();
      checkOutput("hitXE", 32'(posXE), 1720);
      checkOutput("hitYE", 32'(posYE), 442);
      checkOutput("hitEdgeE", 32'(atEdgeE), 1);
      checkOutput("hitXC", 32'(posXC), 0);
      checkOutput("hitYC", 32'(posYC), 0);
      checkOutput("hitEdgeC", 32'(atEdgeC), 1);
      for (int i = 1; i <= 30; i++) begin
         pulseFrame();
         checkOutput("pauseEdgeE", 32'(atEdgeE), (i < 30) ? 1 : 0);
         checkOutput("pauseEdgeC", 32'(atEdgeC), (i < 30) ? 1 : 0);
         checkOutput("pauseXE", 32'(posXE), 1720);
      end
      pulseFrame();
      checkOutput("bounceXE", 32'(posXE), 1718);
      checkOutput("bounceYE", 32'(posYE), 444);
      checkOutput("bounceXC", 32'(posXC), 2);
      checkOutput("bounceYC", 32'(posYC), 2);
      checkOutput("bounceEdgeC", 32'(atEdgeC), 0);
      checkPos("mainIdle", 760, 440);

      for (int k = 0; k < 20 && (addrQ.size() > 0 || rgbQ.size() > 0); k++) begin
         @(negedge clk);
      end
      checkOutput("sbDrain", 32'(addrQ.size() + rgbQ.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
